// File: rtl/l2_line_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_pkg                                                          |
// | Purpose  : Shared types and constants for the L2 line responder: top-level |
// |            state encoding, AXI4 read-channel constants and the cache line  |
// |            view used by the lookup path.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package l2_pkg;

   localparam int L2_LINE_COUNT     = 256;
   localparam int L2_BEATS          = 8;
   localparam int L2_BYTES_PER_LINE = 64;
   localparam int L2_LINE_BITS      = L2_BYTES_PER_LINE * 8;
   localparam int L2_TAG_BITS       = 64 - $clog2(L2_LINE_COUNT) - $clog2(L2_BYTES_PER_LINE);

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [2:0] ARSIZE_8B  = 3'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      AR      = 3'd2,
      R_FILL  = 3'd3,
      RESPOND = 3'd4
   } l2_state_t;

   typedef struct packed {
      logic [L2_LINE_BITS-1:0] data;
      logic                    valid;
      logic [L2_TAG_BITS-1:0]  tag;
   } cache_line_t;

endpackage
`default_nettype wire

// File: rtl/l2_line_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_line_if / axi_rd_if                                          |
// | Purpose  : Bundles for the L1 line-read handshake and the AXI4 read        |
// |            address/data channels.                                          |
// | Ports    : l2_line_if - L2_S_R_ADDR/VALID and INV_ALL from the requester,  |
// |            L2_S_R_DATA/DATA_VALID/RESP_ERR back to it.                     |
// |            axi_rd_if  - m_axi_ar* and m_axi_r* signals of one read port.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface l2_line_if
   import l2_pkg::*;
#(
   parameter int LINE_BITS = L2_LINE_BITS
);
   logic [63:0]          L2_S_R_ADDR;
   logic                 L2_S_R_ADDR_VALID;
   logic [LINE_BITS-1:0] L2_S_R_DATA;
   logic                 L2_S_R_DATA_VALID;
   logic                 RESP_ERR;
   logic                 INV_ALL;

   modport master (
      output L2_S_R_ADDR, L2_S_R_ADDR_VALID, INV_ALL,
      input  L2_S_R_DATA, L2_S_R_DATA_VALID, RESP_ERR
   );

   modport slave (
      input  L2_S_R_ADDR, L2_S_R_ADDR_VALID, INV_ALL,
      output L2_S_R_DATA, L2_S_R_DATA_VALID, RESP_ERR
   );
endinterface

interface axi_rd_if;
   logic [63:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
   );
endinterface
`default_nettype wire

// File: rtl/l2_line_responder_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_axi_line_fill                                                |
// | Purpose  : Fetches one cache line with a single AXI4 INCR read burst and   |
// |            assembles the beats into a line buffer.                         |
// | Ports    : clk, reset - clock, synchronous active-high reset               |
// |            start      - one-cycle request to fetch the line at addr        |
// |            addr       - any byte address inside the wanted line            |
// |            done       - one-cycle pulse, line/err valid with it            |
// |            line       - assembled line, beat k at bits [64k+63:64k]        |
// |            err        - non-OKAY response or rlast/beat-count mismatch     |
// |            axi        - AXI4 read channels (master side)                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module l2_axi_line_fill
   import l2_pkg::*;
#(
   parameter int BEATS       = L2_BEATS,
   parameter int OFFSET_SIZE = $clog2(L2_BYTES_PER_LINE)
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [63:0]          addr,
   output logic                 done,
   output logic [64*BEATS-1:0]  line,
   output logic                 err,
   axi_rd_if.master             axi
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] F_IDLE = 2'd0;
   localparam logic [1:0] F_AR   = 2'd1;
   localparam logic [1:0] F_R    = 2'd2;

   logic [1:0]          r_phase;
   logic [63:0]         r_araddr;
   logic [CNT_W-1:0]    r_cnt;
   logic [64*BEATS-1:0] r_buf;
   logic                r_sticky;
   logic                r_done;
   logic                r_err;

   logic                w_beat;
   logic                w_cnt_last;
   logic                w_last_beat;
   logic                w_err_now;
   logic                w_unused_offset;

   assign w_unused_offset = ^addr[OFFSET_SIZE-1:0];

   assign w_beat      = (r_phase == F_R) && axi.m_axi_rvalid;
   assign w_cnt_last  = (r_cnt == CNT_W'(BEATS-1));
   // The burst ends on whichever of rlast / final count shows up first.
   assign w_last_beat = axi.m_axi_rlast || w_cnt_last;
   assign w_err_now   = r_sticky || (axi.m_axi_rresp != RESP_OKAY);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase  <= F_IDLE;
         r_araddr <= '0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_phase)
            F_IDLE: begin
               if (start) begin
                  r_araddr <= {addr[63:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
                  r_phase  <= F_AR;
               end
            end
            F_AR: begin
               if (axi.m_axi_arready) begin
                  r_cnt    <= '0;
                  r_sticky <= 1'b0;
                  r_phase  <= F_R;
               end
            end
            F_R: begin
               if (axi.m_axi_rvalid) begin
                  r_cnt    <= r_cnt + CNT_W'(1);
                  r_sticky <= w_err_now;
                  if (w_last_beat) begin
                     r_done  <= 1'b1;
                     // A short or over-long burst is as untrustworthy as a bad rresp.
                     r_err   <= w_err_now || (axi.m_axi_rlast != w_cnt_last);
                     r_phase <= F_IDLE;
                  end
               end
            end
            default: r_phase <= F_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_buf[64*r_cnt +: 64] <= axi.m_axi_rdata;
      end
   end

   assign done = r_done;
   assign line = r_buf;
   assign err  = r_err;

   assign axi.m_axi_araddr  = r_araddr;
   assign axi.m_axi_arlen   = 8'(BEATS-1);
   assign axi.m_axi_arsize  = ARSIZE_8B;
   assign axi.m_axi_arburst = BURST_INCR;
   assign axi.m_axi_arvalid = (r_phase == F_AR);
   assign axi.m_axi_rready  = (r_phase == F_R);

endmodule
`default_nettype wire

// File: rtl/l2_line_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : l2_line_responder                                               |
// | Purpose  : Direct-mapped L2 line server. Hits are answered from the local  |
// |            array; misses fetch the line over AXI4, install it when clean   |
// |            and then answer.                                                |
// | Ports    : clk, reset - clock, synchronous active-high reset               |
// |            l1         - L1 line-read handshake and INV_ALL (slave side)    |
// |            axi        - AXI4 read channels towards memory (master side)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module l2_line_responder
   import l2_pkg::*;
#(
   parameter int LINE_COUNT     = L2_LINE_COUNT,
   parameter int BYTES_PER_LINE = L2_BYTES_PER_LINE,
   parameter int INDEX_SIZE     = $clog2(LINE_COUNT),
   parameter int OFFSET_SIZE    = $clog2(BYTES_PER_LINE),
   parameter int TAG_SIZE       = 64 - INDEX_SIZE - OFFSET_SIZE,
   parameter int BEATS          = L2_BEATS
)
(
   input  logic      clk,
   input  logic      reset,
   l2_line_if.slave  l1,
   axi_rd_if.master  axi
);

   localparam int LINE_W = BYTES_PER_LINE * 8;

   l2_state_t         r_state;
   l2_state_t         w_next;

   logic [63:0]       r_addr;
   logic [LINE_COUNT-1:0] r_valid;
   logic [TAG_SIZE-1:0]   r_tag_mem  [LINE_COUNT];
   logic [LINE_W-1:0]     r_data_mem [LINE_COUNT];
   logic [LINE_W-1:0] r_rdata;
   logic              r_resp_err;
   logic              r_inv_pend;

   logic [INDEX_SIZE-1:0] w_index;
   logic [TAG_SIZE-1:0]   w_tag;
   cache_line_t       w_entry;
   logic              w_hit;
   logic              w_inv_now;
   logic              w_accept;
   logic              w_inv_clear;
   logic              w_load_hit;
   logic              w_fill_start;
   logic              w_fill_end;
   logic              w_install;

   logic              w_fill_done;
   logic [LINE_W-1:0] w_fill_line;
   logic              w_fill_err;

   assign w_index = r_addr[OFFSET_SIZE +: INDEX_SIZE];
   assign w_tag   = r_addr[63 -: TAG_SIZE];

   always_comb begin
      w_entry.data  = r_data_mem[w_index];
      w_entry.valid = r_valid[w_index];
      w_entry.tag   = r_tag_mem[w_index];
   end

   assign w_hit     = w_entry.valid && (w_entry.tag == w_tag);
   assign w_inv_now = l1.INV_ALL || r_inv_pend;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!w_inv_now && l1.L2_S_R_ADDR_VALID) w_next = LOOKUP;
         LOOKUP:  w_next = w_hit ? RESPOND : AR;
         AR:      if (axi.m_axi_arvalid && axi.m_axi_arready) w_next = R_FILL;
         R_FILL:  if (w_fill_done) w_next = RESPOND;
         RESPOND: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      // An invalidate owns the IDLE cycle; the held request is taken next cycle.
      w_inv_clear  = (r_state == IDLE) && w_inv_now;
      w_accept     = (r_state == IDLE) && !w_inv_now && l1.L2_S_R_ADDR_VALID;
      w_load_hit   = (r_state == LOOKUP) && w_hit;
      w_fill_start = (r_state == LOOKUP) && !w_hit;
      w_fill_end   = (r_state == R_FILL) && w_fill_done;
      w_install    = w_fill_end && !w_fill_err;
   end

   assign l1.L2_S_R_DATA       = r_rdata;
   assign l1.L2_S_R_DATA_VALID = (r_state == RESPOND);
   assign l1.RESP_ERR          = r_resp_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr     <= '0;
         r_valid    <= '0;
         r_rdata    <= '0;
         r_resp_err <= 1'b0;
         r_inv_pend <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= l1.L2_S_R_ADDR;
         end

         if (w_load_hit) begin
            r_rdata    <= w_entry.data;
            r_resp_err <= 1'b0;
         end else if (w_fill_end) begin
            r_rdata    <= w_fill_line;
            r_resp_err <= w_fill_err;
         end else if (r_state == RESPOND) begin
            r_resp_err <= 1'b0;
         end

         // Install and invalidate live in different states, so they never collide;
         // a line installed while an invalidate is pending is cleared in IDLE.
         if (w_inv_clear) begin
            r_valid    <= '0;
            r_inv_pend <= 1'b0;
         end else begin
            if (l1.INV_ALL) begin
               r_inv_pend <= 1'b1;
            end
            if (w_install) begin
               r_valid[w_index] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_install) begin
         r_data_mem[w_index] <= w_fill_line;
         r_tag_mem[w_index]  <= w_tag;
      end
   end

   l2_axi_line_fill #(
      .BEATS       (BEATS),
      .OFFSET_SIZE (OFFSET_SIZE)
   ) u_fill (
      .clk   (clk),
      .reset (reset),
      .start (w_fill_start),
      .addr  (r_addr),
      .done  (w_fill_done),
      .line  (w_fill_line),
      .err   (w_fill_err),
      .axi   (axi)
   );

endmodule
`default_nettype wire
